step_pulse_ctrl: RTL and testbench
==================================

// Module: step_pulse_ctrl
// PURPOSE
//  Parametrised step generator that gates the MIPS CPU clock-enable for download and debug.
//  - Generates a post-reset init pulse of configurable length.
//  - Supports four step modes: stop, free-run, single-step per button press, and N-step burst.
//  - Counts the steps issued.
//  - Sits between board buttons/switches and the CPU core enable.
// PARAMETERS
//  INIT_LEN    1   cycles init_pulse stays high after reset release (>=1)
//  DEB_CYCLES  4   consecutive equal synced samples needed to accept a new button level (>=1)
//  BURST_W     8   width of burst_len
//  CNT_W       16  width of step_cnt
// PORTS
//  myClk       in   1        clock
//  rst         in   1        reset; asynchronous, active-high
//  mode        in   2        00 STOP, 01 RUN, 10 SINGLE, 11 BURST
//  step_btn    in   1        raw, asynchronous push-button
//  burst_len   in   BURST_W  steps per press in BURST mode; sampled at the press
//  halt        in   1        synchronous abort/inhibit
//  step_en     out  1        registered CPU enable; one cycle high = one step
//  busy        out  1        registered; high while RUN is issuing or a burst is in flight
//  init_pulse  out  1        high during reset and for INIT_LEN cycles after release
//  step_cnt    out  CNT_W    total steps issued, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset values:
//   - step_en=0, busy=0, init_pulse=1, step_cnt=0.
//   - FSM=IDLE; init counter=0; debounced level=0; sync FFs=0.
//  Init counter:
//   - Increments each cycle, saturating at INIT_LEN.
//   - init_pulse = (cnt < INIT_LEN).
//   - While init_pulse=1, step_en is forced 0 and presses are discarded.
//  Button input:
//   - 2-FF synchroniser, then debounce counter.
//   - The debounced level toggles after DEB_CYCLES consecutive synced samples differing from it.
//   - press = debounced rising edge, a one-cycle internal strobe.
//  FSM states: IDLE, BURST, WAIT_REL.
//   - IDLE, mode=SINGLE, press -> step_en=1 for exactly one cycle -> WAIT_REL.
//   - IDLE, mode=BURST, press, burst_len!=0 -> latch remaining=burst_len -> BURST.
//   - IDLE, mode=BURST, press, burst_len=0 -> WAIT_REL; no step issued.
//   - BURST: step_en=1 on each consecutive cycle; remaining decrements.
//     The last step returns to WAIT_REL, so exactly burst_len steps are issued.
//   - WAIT_REL -> IDLE once the debounced level is 0. A held button never re-triggers.
//   - RUN: step_en=1 every cycle while mode=RUN, !halt and !init_pulse. The FSM stays IDLE.
//   - STOP: step_en=0, FSM -> IDLE.
//  Latency:
//   - step_en is registered.
//   - First step_en cycle is one cycle after the press strobe.
//   - Press strobe is 2 (sync) + DEB_CYCLES cycles after the raw edge.
//  halt:
//   - halt=1 at edge k -> step_en=0 from edge k onward; a BURST aborts to WAIT_REL.
//   - A press coinciding with halt is discarded.
//  Mode change:
//   - Any mode change while in BURST aborts to WAIT_REL, with step_en=0 on the same edge.
//   - A press during BURST is ignored.
//  step_cnt:
//   - +1 on every cycle step_en=1.
//   - Wraps from 2^CNT_W-1 to 0 with no flag.
//  busy:
//   - busy = (FSM==BURST) | (mode==RUN & !halt & !init_pulse), registered alongside step_en.
//  rst asserted mid-burst:
//   - Immediately returns all state to reset values.
//   - init_pulse restarts.
// STRUCTURE
//  Shared package:
//   - mode encodings: MODE_STOP/RUN/SINGLE/BURST.
//   - FSM state encodings: S_IDLE/S_BURST/S_WAIT_REL.
//  Sub-module: btn_debounce (sync + debounce + rising-edge strobe), parametrised by DEB_CYCLES.
// TESTING
//  T1:
//   - Stimulus: reset, INIT_LEN=3.
//   - Required: init_pulse=1 during rst and 3 cycles after release, then 0 permanently.
//   - Required: mode=RUN held meanwhile gives step_en=0 until init_pulse falls.
//  T2:
//   - Stimulus: SINGLE, button held 50 cycles.
//   - Required: exactly 1 step_en cycle, step_cnt=1.
//   - Required: release then re-press gives step_cnt=2.
//   - Required: 2-cycle glitch on step_btn (DEB_CYCLES=4) gives no step.
//  T3:
//   - Stimulus: BURST, burst_len=5, one press.
//   - Required: 5 consecutive step_en cycles, step_cnt+=5, busy high for those 5 cycles.
//   - Required: burst_len=0 gives no step.
//  T4:
//   - Stimulus: BURST, burst_len=200; halt pulsed after step 10.
//   - Required: step_en=0 from that edge, step_cnt=10.
//   - Required: a second press after release starts a fresh 200-step burst.
//  T5:
//   - Stimulus: RUN with CNT_W=4 for 20 cycles.
//   - Required: step_cnt wraps 15->0 and reads 4.
//   - Required: switching to STOP gives step_en=0 on the next edge.
//  T6:
//   - Stimulus: rst asserted mid-burst.
//   - Required: step_en, busy and step_cnt clear asynchronously and init_pulse=1.

Source files
------------

// File: rtl/step_pulse_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_ctrl_pkg
// Description : Shared encodings for the step pulse controller: the step-mode
//               selector seen on the board switches and the controller FSM
//               state.
// Revision    : 1.0 - initial release
// ============================================================================
package step_pulse_ctrl_pkg;

    // Step-mode selector, as wired from the board switches
    typedef enum logic [1:0] {
        MODE_STOP   = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_SINGLE = 2'b10,
        MODE_BURST  = 2'b11
    } mode_e;

    // Controller FSM state
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BURST    = 2'd1,
        S_WAIT_REL = 2'd2
    } state_e;

endpackage : step_pulse_ctrl_pkg
`default_nettype wire

// File: rtl/step_pulse_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_ctrl_if
// Description : Control/status bundle between the board-side logic (master)
//               and the step pulse controller (slave).
//   mode       master->slave  step mode selector
//   step_btn   master->slave  raw asynchronous push-button
//   burst_len  master->slave  steps per press in BURST mode
//   halt       master->slave  synchronous abort/inhibit
//   step_en    slave->master  CPU clock-enable, one cycle high = one step
//   busy       slave->master  RUN issuing or burst in flight
//   init_pulse slave->master  post-reset init pulse
//   step_cnt   slave->master  total steps issued (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
interface step_pulse_ctrl_if
    import step_pulse_ctrl_pkg::*;
#(
    parameter int BURST_W = 8,
    parameter int CNT_W   = 16
);
    mode_e              mode;
    logic               step_btn;
    logic [BURST_W-1:0] burst_len;
    logic               halt;
    logic               step_en;
    logic               busy;
    logic               init_pulse;
    logic [CNT_W-1:0]   step_cnt;

    modport master (
        output mode, step_btn, burst_len, halt,
        input  step_en, busy, init_pulse, step_cnt
    );

    modport slave (
        input  mode, step_btn, burst_len, halt,
        output step_en, busy, init_pulse, step_cnt
    );
endinterface : step_pulse_ctrl_if
`default_nettype wire

// File: rtl/step_pulse_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, debounce counter and rising-edge strobe
//               for a raw push-button.
//   myClk   in   clock
//   rst     in   asynchronous active-high reset
//   btnRaw  in   raw asynchronous button
//   level   out  debounced button level
//   press   out  one-cycle strobe on a debounced rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  wire logic myClk,
    input  wire logic rst,
    input  wire logic btnRaw,
    output logic      level,
    output logic      press
);
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [DEB_W-1:0] r_debCnt;
    logic             w_differs;
    logic             w_accept;

    assign w_differs = (r_sync2 != r_level);
    // The current sample is the DEB_CYCLES-th consecutive differing one
    assign w_accept  = w_differs && (r_debCnt == DEB_W'(DEB_CYCLES - 1));

    always_ff @(posedge myClk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_press  <= 1'b0;
            r_debCnt <= '0;
        end else begin
            r_sync1 <= btnRaw;
            r_sync2 <= r_sync1;
            r_press <= w_accept && r_sync2;
            if (w_accept) begin
                r_level  <= r_sync2;
                r_debCnt <= '0;
            end else if (w_differs) begin
                r_debCnt <= r_debCnt + DEB_W'(1);
            end else begin
                r_debCnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;
endmodule : btn_debounce
`default_nettype wire

// File: rtl/step_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_ctrl
// Description : Step generator gating the CPU clock-enable for download and
//               debug: post-reset init pulse, STOP/RUN/SINGLE/BURST step
//               modes and a wrapping step counter.
//   myClk  in     clock
//   rst    in     asynchronous active-high reset
//   bus    slave  mode/step_btn/burst_len/halt in,
//                 step_en/busy/init_pulse/step_cnt out
// Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_ctrl
    import step_pulse_ctrl_pkg::*;
#(
    parameter int INIT_LEN   = 1,
    parameter int DEB_CYCLES = 4,
    parameter int BURST_W    = 8,
    parameter int CNT_W      = 16
) (
    input wire logic         myClk,
    input wire logic         rst,
    step_pulse_ctrl_if.slave bus
);
    localparam int INIT_W = $clog2(INIT_LEN + 1);

    state_e             r_state;
    state_e             w_stateNext;
    logic [BURST_W-1:0] r_remaining;
    logic [BURST_W-1:0] w_remNext;
    logic [INIT_W-1:0]  r_initCnt;
    logic               r_stepEn;
    logic               r_busy;
    logic [CNT_W-1:0]   r_stepCnt;
    logic               w_stepNext;
    logic               w_burstStep;
    logic               w_runStep;
    logic               w_pressOk;
    logic               w_initPulse;
    logic               w_level;
    logic               w_press;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btnDebounce (
        .myClk  (myClk),
        .rst    (rst),
        .btnRaw (bus.step_btn),
        .level  (w_level),
        .press  (w_press)
    );

    assign w_initPulse = (r_initCnt < INIT_W'(INIT_LEN));
    assign w_pressOk   = w_press && !bus.halt && !w_initPulse;

    always_comb begin
        w_stateNext = r_state;
        w_remNext   = r_remaining;
        w_stepNext  = 1'b0;
        w_burstStep = 1'b0;
        // RUN issues independently of SINGLE/BURST bookkeeping, but a mode
        // change out of BURST must leave the abort edge silent
        w_runStep   = (bus.mode == MODE_RUN) && !bus.halt && !w_initPulse &&
                      (r_state != S_BURST);

        case (r_state)
            S_IDLE: begin
                case (bus.mode)
                    MODE_SINGLE: begin
                        if (w_pressOk) begin
                            w_stepNext  = 1'b1;
                            w_stateNext = S_WAIT_REL;
                        end
                    end
                    MODE_BURST: begin
                        if (w_pressOk) begin
                            if (bus.burst_len == '0) begin
                                w_stateNext = S_WAIT_REL;
                            end else begin
                                // First burst step issues on the same edge
                                // the length is latched
                                w_stepNext  = 1'b1;
                                w_burstStep = 1'b1;
                                if (bus.burst_len == BURST_W'(1)) begin
                                    w_stateNext = S_WAIT_REL;
                                end else begin
                                    w_remNext   = bus.burst_len - BURST_W'(1);
                                    w_stateNext = S_BURST;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
            S_BURST: begin
                if (bus.halt || (bus.mode != MODE_BURST)) begin
                    w_stateNext = S_WAIT_REL;
                end else begin
                    w_stepNext  = 1'b1;
                    w_burstStep = 1'b1;
                    w_remNext   = r_remaining - BURST_W'(1);
                    if (r_remaining == BURST_W'(1)) begin
                        w_stateNext = S_WAIT_REL;
                    end
                end
            end
            S_WAIT_REL: begin
                if (!w_level) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase

        if ((bus.mode == MODE_STOP) && (r_state != S_BURST)) begin
            w_stateNext = S_IDLE;
        end

        if (w_runStep) begin
            w_stepNext = 1'b1;
        end
    end

    always_ff @(posedge myClk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_initCnt   <= '0;
            r_stepEn    <= 1'b0;
            r_busy      <= 1'b0;
            r_stepCnt   <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_remaining <= w_remNext;
            if (w_initPulse) begin
                r_initCnt <= r_initCnt + INIT_W'(1);
            end
            r_stepEn <= w_stepNext;
            r_busy   <= w_burstStep || w_runStep;
            // Counter tracks the step being issued on this edge
            if (w_stepNext) begin
                r_stepCnt <= r_stepCnt + CNT_W'(1);
            end
        end
    end

    assign bus.step_en    = r_stepEn;
    assign bus.busy       = r_busy;
    assign bus.init_pulse = w_initPulse;
    assign bus.step_cnt   = r_stepCnt;
endmodule : step_pulse_ctrl
`default_nettype wire

// File: tb/tb_step_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_pulse_ctrl
// Description : Directed self-checking bench for step_pulse_ctrl
//               (INIT_LEN=3, DEB_CYCLES=4, BURST_W=8, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_pulse_ctrl;
    import step_pulse_ctrl_pkg::*;

    logic myClk;
    logic rst;
    int   nAssert;
    int   nFail;
    int   expCnt;
    int   steps;
    int   busyN;
    int   maxRun;

    step_pulse_ctrl_if #(.BURST_W(8), .CNT_W(4)) bus ();

    step_pulse_ctrl #(
        .INIT_LEN   (3),
        .DEB_CYCLES (4),
        .BURST_W    (8),
        .CNT_W      (4)
    ) dut (
        .myClk (myClk),
        .rst   (rst),
        .bus   (bus)
    );

    initial myClk = 1'b0;
    always #5 myClk = ~myClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nAssert++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge myClk);
        #1;
    endtask

    // Advance n cycles, counting step_en cycles, busy cycles and longest step run
    task automatic runCount(input int n, output int st, output int bz, output int mr);
        int run;
        st  = 0;
        bz  = 0;
        mr  = 0;
        run = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.step_en === 1'b1) begin
                st++;
                run++;
                if (run > mr) mr = run;
            end else begin
                run = 0;
            end
            if (bus.busy === 1'b1) bz++;
        end
    endtask

    initial begin
        nAssert = 0;
        nFail   = 0;
        expCnt  = 0;
        rst           = 1'b1;
        bus.mode      = MODE_RUN;
        bus.step_btn  = 1'b0;
        bus.burst_len = 8'd0;
        bus.halt      = 1'b0;

        // T1: reset state and init pulse with RUN held
        repeat (2) tick();
        check("rst init_pulse", 32'(bus.init_pulse), 32'd1);
        check("rst step_en",    32'(bus.step_en),    32'd0);
        check("rst busy",       32'(bus.busy),       32'd0);
        check("rst step_cnt",   32'(bus.step_cnt),   32'd0);
        rst = 1'b0;
        tick();
        check("t1 init e1",  32'(bus.init_pulse), 32'd1);
        check("t1 en e1",    32'(bus.step_en),    32'd0);
        tick();
        check("t1 init e2",  32'(bus.init_pulse), 32'd1);
        check("t1 en e2",    32'(bus.step_en),    32'd0);
        tick();
        check("t1 init e3",  32'(bus.init_pulse), 32'd0);
        check("t1 en e3",    32'(bus.step_en),    32'd0);
        tick();
        expCnt = 1;
        check("t1 en e4",    32'(bus.step_en),    32'd1);
        check("t1 busy e4",  32'(bus.busy),       32'd1);
        check("t1 cnt e4",   32'(bus.step_cnt),   32'(expCnt));
        check("t1 init e4",  32'(bus.init_pulse), 32'd0);
        bus.mode = MODE_STOP;
        tick();
        check("t1 stop en",   32'(bus.step_en),  32'd0);
        check("t1 stop busy", 32'(bus.busy),     32'd0);

        // T2: SINGLE with held button, latency, re-press and glitch
        bus.mode     = MODE_SINGLE;
        bus.step_btn = 1'b1;
        repeat (6) tick();
        check("t2 latency en0", 32'(bus.step_en), 32'd0);
        tick();
        check("t2 first en",    32'(bus.step_en), 32'd1);
        check("t2 single busy", 32'(bus.busy),    32'd0);
        runCount(43, steps, busyN, maxRun);
        check("t2 held extra steps", 32'(steps), 32'd0);
        expCnt = 2;
        check("t2 cnt1", 32'(bus.step_cnt), 32'(expCnt));
        bus.step_btn = 1'b0;
        runCount(12, steps, busyN, maxRun);
        bus.step_btn = 1'b1;
        runCount(20, steps, busyN, maxRun);
        check("t2 repress steps", 32'(steps), 32'd1);
        expCnt = 3;
        check("t2 cnt2", 32'(bus.step_cnt), 32'(expCnt));
        bus.step_btn = 1'b0;
        runCount(12, steps, busyN, maxRun);
        bus.step_btn = 1'b1;
        tick();
        tick();
        bus.step_btn = 1'b0;
        runCount(15, steps, busyN, maxRun);
        check("t2 glitch steps", 32'(steps), 32'd0);
        check("t2 glitch cnt",   32'(bus.step_cnt), 32'(expCnt));

        // T3: BURST of 5, then burst_len=0
        bus.mode      = MODE_BURST;
        bus.burst_len = 8'd5;
        bus.step_btn  = 1'b1;
        runCount(20, steps, busyN, maxRun);
        check("t3 burst steps", 32'(steps),  32'd5);
        check("t3 burst busy",  32'(busyN),  32'd5);
        check("t3 burst run",   32'(maxRun), 32'd5);
        expCnt = 8;
        check("t3 cnt", 32'(bus.step_cnt), 32'(expCnt));
        bus.step_btn = 1'b0;
        runCount(12, steps, busyN, maxRun);
        bus.burst_len = 8'd0;
        bus.step_btn  = 1'b1;
        runCount(20, steps, busyN, maxRun);
        check("t3 zero steps", 32'(steps), 32'd0);
        check("t3 zero busy",  32'(busyN), 32'd0);
        bus.step_btn = 1'b0;
        runCount(12, steps, busyN, maxRun);

        // T4: 200-step burst aborted by halt after step 10, then a fresh burst
        bus.burst_len = 8'd200;
        bus.step_btn  = 1'b1;
        repeat (6) tick();
        check("t4 latency en0", 32'(bus.step_en), 32'd0);
        runCount(10, steps, busyN, maxRun);
        check("t4 pre-halt steps", 32'(steps), 32'd10);
        check("t4 pre-halt busy",  32'(busyN), 32'd10);
        bus.halt = 1'b1;
        tick();
        check("t4 halt en",   32'(bus.step_en), 32'd0);
        check("t4 halt busy", 32'(bus.busy),    32'd0);
        bus.halt = 1'b0;
        expCnt = (8 + 10) % 16;
        check("t4 halt cnt", 32'(bus.step_cnt), 32'(expCnt));
        runCount(20, steps, busyN, maxRun);
        check("t4 held no retrigger", 32'(steps), 32'd0);
        bus.step_btn = 1'b0;
        runCount(12, steps, busyN, maxRun);
        bus.step_btn = 1'b1;
        runCount(220, steps, busyN, maxRun);
        check("t4 full steps", 32'(steps),  32'd200);
        check("t4 full busy",  32'(busyN),  32'd200);
        check("t4 full run",   32'(maxRun), 32'd200);
        expCnt = (expCnt + 200) % 16;
        check("t4 full cnt", 32'(bus.step_cnt), 32'(expCnt));
        bus.step_btn = 1'b0;
        runCount(12, steps, busyN, maxRun);

        // T5: RUN with wrap, halt inhibit, then STOP
        bus.mode = MODE_RUN;
        runCount(20, steps, busyN, maxRun);
        check("t5 run steps", 32'(steps), 32'd20);
        check("t5 run busy",  32'(busyN), 32'd20);
        expCnt = (expCnt + 20) % 16;
        check("t5 run cnt", 32'(bus.step_cnt), 32'(expCnt));
        bus.halt = 1'b1;
        tick();
        check("t5 halt en",   32'(bus.step_en),  32'd0);
        check("t5 halt busy", 32'(bus.busy),     32'd0);
        check("t5 halt cnt",  32'(bus.step_cnt), 32'(expCnt));
        bus.halt = 1'b0;
        tick();
        check("t5 cnt 15", 32'(bus.step_cnt), 32'd15);
        tick();
        check("t5 wrap 0", 32'(bus.step_cnt), 32'd0);
        bus.mode = MODE_STOP;
        tick();
        check("t5 stop en",   32'(bus.step_en), 32'd0);
        check("t5 stop busy", 32'(bus.busy),    32'd0);

        // T6: asynchronous reset mid-burst
        bus.mode      = MODE_BURST;
        bus.burst_len = 8'd50;
        bus.step_btn  = 1'b1;
        repeat (11) tick();
        check("t6 mid en",   32'(bus.step_en),  32'd1);
        check("t6 mid busy", 32'(bus.busy),     32'd1);
        check("t6 mid cnt",  32'(bus.step_cnt), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("t6 async en",   32'(bus.step_en),    32'd0);
        check("t6 async busy", 32'(bus.busy),       32'd0);
        check("t6 async cnt",  32'(bus.step_cnt),   32'd0);
        check("t6 async init", 32'(bus.init_pulse), 32'd1);
        tick();
        rst          = 1'b0;
        bus.step_btn = 1'b0;
        tick();
        tick();
        check("t6 init still high", 32'(bus.init_pulse), 32'd1);
        tick();
        check("t6 init low", 32'(bus.init_pulse), 32'd0);
        check("t6 idle en",  32'(bus.step_en),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule : tb_step_pulse_ctrl
`default_nettype wire
